// File: rtl/cacheline_serializer.sv
`default_nettype none
// ============================================================================
// Module   : cacheline_serializer
// Function : splits a 256-bit cache line write into four 64-bit bmem beats and
//            issues single-cycle line read requests toward bmem.
// Options  : CACHELINE_SERIALIZER_PERF_EN adds saturating performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module cacheline_serializer #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  input  logic [LINE_W-1:0] dfp_wdata,
  input  logic              rd_done,
  output logic              dfp_wresp,
  output logic              busy,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
`ifdef CACHELINE_SERIALIZER_PERF_EN
  output logic [31:0]       perf_rd_lines,
  output logic [31:0]       perf_wr_lines,
  output logic [31:0]       perf_stall_cycles,
`endif
  input  logic              bmem_ready
);

  localparam int NBEAT = LINE_W / BEAT_W;
  localparam int CNT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam int OFFS  = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEAT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_BEAT = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t                         state;
  state_t                         next_state;
  logic [CNT_W-1:0]               cnt;
  logic [ADDR_W-1:0]              line_addr;
  logic [NBEAT-1:0][BEAT_W-1:0]   line_data;
  logic [ADDR_W-1:0]              aligned_addr;
  logic                           unused_addr_bits;

  // The byte offset within a line never reaches bmem.
  assign aligned_addr     = {dfp_addr[ADDR_W-1:OFFS], {OFFS{1'b0}}};
  assign unused_addr_bits = ^dfp_addr[OFFS-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      line_addr <= '0;
      line_data <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE) begin
        if (dfp_write) begin
          line_addr <= aligned_addr;
          line_data <= dfp_wdata;
          cnt       <= '0;
        end else if (dfp_read) begin
          line_addr <= aligned_addr;
        end
      end
      if (state == WR_BEAT && bmem_ready && cnt != LAST_BEAT) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    next_state = state;
    dfp_wresp  = 1'b0;
    bmem_addr  = '0;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_wdata = '0;
    case (state)
      IDLE: begin
        // Writes win; a pending read is level-held and is picked up later.
        if (dfp_write) begin
          next_state = WR_BEAT;
        end else if (dfp_read) begin
          next_state = RD_REQ;
        end
      end
      RD_REQ: begin
        bmem_read = 1'b1;
        bmem_addr = line_addr;
        if (bmem_ready) begin
          next_state = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (rd_done) begin
          next_state = DONE;
        end
      end
      WR_BEAT: begin
        bmem_write = 1'b1;
        bmem_addr  = line_addr;
        bmem_wdata = line_data[cnt];
        if (bmem_ready && cnt == LAST_BEAT) begin
          dfp_wresp  = 1'b1;
          next_state = DONE;
        end
      end
      // One dead cycle so a request the cache has not yet dropped is not re-issued.
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

`ifdef CACHELINE_SERIALIZER_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_rd_lines     <= '0;
      perf_wr_lines     <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (state == RD_REQ && bmem_ready && perf_rd_lines != 32'hFFFF_FFFF) begin
        perf_rd_lines <= perf_rd_lines + 32'd1;
      end
      if (dfp_wresp && perf_wr_lines != 32'hFFFF_FFFF) begin
        perf_wr_lines <= perf_wr_lines + 32'd1;
      end
      if ((bmem_read || bmem_write) && !bmem_ready && perf_stall_cycles != 32'hFFFF_FFFF) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cacheline_serializer.sv
`default_nettype none
// Bench for cacheline_serializer: a transaction-level model predicts each write
// beat, write response and read request; directed vectors pin latencies and data.
module tb_cacheline_serializer;
  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int ADDR_W = 32;
  localparam int NBEAT  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] dfp_addr;
  logic              dfp_read;
  logic              dfp_write;
  logic [LINE_W-1:0] dfp_wdata;
  logic              rd_done;
  logic              dfp_wresp;
  logic              busy;
  logic [ADDR_W-1:0] bmem_addr;
  logic              bmem_read;
  logic              bmem_write;
  logic [BEAT_W-1:0] bmem_wdata;
  logic              bmem_ready;

  cacheline_serializer #(.LINE_W(LINE_W), .BEAT_W(BEAT_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .dfp_addr(dfp_addr), .dfp_read(dfp_read),
    .dfp_write(dfp_write), .dfp_wdata(dfp_wdata), .rd_done(rd_done),
    .dfp_wresp(dfp_wresp), .busy(busy), .bmem_addr(bmem_addr),
    .bmem_read(bmem_read), .bmem_write(bmem_write), .bmem_wdata(bmem_wdata),
    .bmem_ready(bmem_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level model state.
  bit                wr_pend;
  logic [LINE_W-1:0] wr_line;
  logic [ADDR_W-1:0] wr_addr;
  int                beat_idx;
  bit                rd_pend;
  bit                rd_issued;
  logic [ADDR_W-1:0] rd_addr;
  int                cyc, burst_start, wresp_cyc, wresp_cnt, rd_req_cycles, rd_first_cyc;
  bit                prev_write;
  logic [BEAT_W-1:0] seen [NBEAT];
  logic              s_busy, s_read, s_write, s_wresp;
  int                acc_cyc;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called once per cycle at the negative edge, when outputs are settled.
  task automatic compare();
    cyc++;
    s_busy = busy; s_read = bmem_read; s_write = bmem_write; s_wresp = dfp_wresp;
    chk("rd_wr_exclusive", bmem_read & bmem_write, 0);
    if (bmem_write) begin
      chk("unexpected_write", wr_pend, 1);
      chk("wr_addr", bmem_addr, wr_addr & 32'hFFFF_FFE0);
      chk("wr_beat", bmem_wdata, wr_line[beat_idx*BEAT_W +: BEAT_W]);
      if (!prev_write) burst_start = cyc;
    end
    chk("wresp", dfp_wresp, bmem_write && bmem_ready && wr_pend && beat_idx == NBEAT-1);
    if (bmem_write && bmem_ready) begin
      seen[beat_idx] = bmem_wdata;
      if (beat_idx == NBEAT-1) begin
        wr_pend = 0; beat_idx = 0; wresp_cyc = cyc; wresp_cnt++;
      end else begin
        beat_idx++;
      end
    end
    if (bmem_read) begin
      chk("unexpected_read", rd_pend && !rd_issued && !wr_pend, 1);
      chk("rd_addr", bmem_addr, rd_addr & 32'hFFFF_FFE0);
      if (rd_req_cycles == 0) rd_first_cyc = cyc;
      rd_req_cycles++;
      if (bmem_ready) rd_issued = 1;
    end else if (!bmem_write) begin
      chk("idle_bus", {bmem_addr, bmem_wdata}, 0);
    end
    if (rd_issued && !bmem_read) chk("rd_wait_busy", busy, 1);
    prev_write = bmem_write;
    if (rst) begin
      wr_pend = 0; beat_idx = 0; rd_pend = 0; rd_issued = 0; prev_write = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  // Issue a line write; stall_mask bit k drops bmem_ready on burst cycle k+1.
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d,
                          input logic [15:0] stall_mask);
    int n0;
    wr_pend = 1; wr_line = d; wr_addr = a; beat_idx = 0;
    dfp_addr = a; dfp_wdata = d; dfp_write = 1; bmem_ready = 1;
    step();
    acc_cyc = cyc;
    dfp_wdata = ~d;
    dfp_addr  = a ^ 32'hFFFF_0000;
    n0 = wresp_cnt;
    for (int k = 0; k < 16 && wresp_cnt == n0; k++) begin
      bmem_ready = !stall_mask[k];
      step();
    end
    chk("wresp_seen", wresp_cnt, n0 + 1);
    dfp_write = 0; bmem_ready = 1;
  endtask

  localparam logic [LINE_W-1:0] L0 = {64'd3, 64'd2, 64'd1, 64'd0};
  localparam logic [LINE_W-1:0] L1 = {64'hDDDD_DDDD_DDDD_DDD3, 64'hCCCC_CCCC_CCCC_CCC2,
                                      64'hBBBB_BBBB_BBBB_BBB1, 64'hAAAA_AAAA_AAAA_AAA0};
  localparam logic [LINE_W-1:0] L2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                      64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
  localparam logic [LINE_W-1:0] L3 = {64'h3333_0000_0000_0003, 64'h2222_0000_0000_0002,
                                      64'h1111_0000_0000_0001, 64'h0F0F_0000_0000_0000};
  localparam logic [LINE_W-1:0] L4 = {64'h9999_8888_7777_6666, 64'h5555_4444_3333_2222,
                                      64'h1234_1234_1234_1234, 64'hCAFE_F00D_DEAD_BEEF};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; dfp_addr = 32'hAAAAA01C; dfp_read = 0; dfp_write = 1; dfp_wdata = L0;
    rd_done = 0; bmem_ready = 1;

    // Reset held with a write request present: everything quiet.
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_busy", s_busy, 0);
      chk("rst_write", s_write, 0);
      chk("rst_read", s_read, 0);
      chk("rst_wresp", s_wresp, 0);
    end
    rst = 0;

    // Plain write, ready always high.
    do_write(32'hAAAAA01C, L0, 16'h0000);
    chk("first_write_lat", burst_start - acc_cyc, 1);
    chk("wr_burst_len", wresp_cyc - burst_start, 3);
    chk("beat0_lit", seen[0], 64'd0);
    chk("beat3_lit", seen[3], 64'd3);
    step();
    chk("done_busy", s_busy, 1);
    chk("done_write", s_write, 0);
    step();
    chk("idle_busy", s_busy, 0);

    // rd_done outside RD_WAIT is ignored.
    rd_done = 1; step(); rd_done = 0; step();
    chk("stray_rd_done", s_busy, 0);

    // Write with ready low on burst cycles 2 and 3.
    do_write(32'h1234_5678, L1, 16'h0006);
    chk("stall_burst_len", wresp_cyc - burst_start, 5);
    chk("stall_beat1_lit", seen[1], 64'hBBBB_BBBB_BBBB_BBB1);
    chk("stall_beat3_lit", seen[3], 64'hDDDD_DDDD_DDDD_DDD3);
    step(); step();

    // Line read, ready low on the first request cycle.
    rd_pend = 1; rd_issued = 0; rd_addr = 32'hAAAAA040; rd_req_cycles = 0;
    dfp_addr = 32'hAAAAA040; dfp_read = 1;
    step();
    bmem_ready = 0; step();
    bmem_ready = 1; step();
    step();
    chk("rd_req_cycles", rd_req_cycles, 2);
    chk("rd_issued", rd_issued, 1);
    chk("rd_req_dropped", s_read, 0);
    for (int i = 0; i < 9; i++) step();
    chk("rd_wait_busy_lit", s_busy, 1);
    rd_done = 1; dfp_read = 0; step();
    rd_done = 0; rd_pend = 0; rd_issued = 0;
    step();
    chk("rd_done_busy", s_busy, 1);
    step();
    chk("rd_idle_busy", s_busy, 0);

    // Simultaneous read and write: write goes first, held read follows.
    rd_pend = 1; rd_issued = 0; rd_addr = 32'hBEEF_0123; rd_req_cycles = 0;
    dfp_read = 1;
    do_write(32'h0000_1F80, L2, 16'h0000);
    dfp_addr = 32'hBEEF_0123;
    for (int i = 0; i < 10 && !rd_issued; i++) step();
    chk("sim_rd_issued", rd_issued, 1);
    chk("sim_rd_after_wr", rd_first_cyc - wresp_cyc, 3);
    chk("sim_beat2_lit", seen[2], 64'hFEDC_BA98_7654_3210);
    for (int i = 0; i < 3; i++) step();
    rd_done = 1; dfp_read = 0; step();
    rd_done = 0; rd_pend = 0; rd_issued = 0;
    step(); step();
    chk("sim_idle_busy", s_busy, 0);

    // Reset in the middle of a write burst, after beat 1.
    wr_pend = 1; wr_line = L3; wr_addr = 32'h0000_4000; beat_idx = 0;
    dfp_addr = 32'h0000_4000; dfp_wdata = L3; dfp_write = 1; bmem_ready = 1;
    step();
    step();
    step();
    chk("pre_rst_beat1", seen[1], 64'h1111_0000_0000_0001);
    begin
      int n0;
      n0 = wresp_cnt;
      rst = 1; bmem_ready = 0;
      step();
      rst = 0; dfp_write = 0; bmem_ready = 1;
      step();
      chk("post_rst_write", s_write, 0);
      chk("post_rst_busy", s_busy, 0);
      chk("post_rst_wresp", s_wresp, 0);
      chk("post_rst_no_resp", wresp_cnt, n0);
    end
    do_write(32'h0000_8020, L4, 16'h0000);
    chk("restart_beat0_lit", seen[0], 64'hCAFE_F00D_DEAD_BEEF);
    chk("restart_burst_len", wresp_cyc - burst_start, 3);
    step(); step();
    chk("final_idle", s_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
